// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX-stage controller and the HI/LO unit.
// The controller drives the master side; the unit is the slave.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative shift-add multiply and
// restoring divide engine; all state advances on the falling clock edge.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e          state_q;
  logic [W-1:0]    hi_q, lo_q, dvs_q, a_q;
  logic [2*W:0]    work_q;
  logic [CW-1:0]   count_q;
  logic            busy_q, done_q;
  logic            is_div_q, neg_q, negr_q, bz_q;

  logic            sgn, is_md, is_dv;
  logic [W-1:0]    abs_a, abs_b;
  logic [W:0]      mul_sum, div_rs;
  logic            div_ge;
  logic [W-1:0]    div_r;
  logic [2*W:0]    step_d;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem;
  logic [W-1:0]    hi_d, lo_d;

  always_comb begin
    sgn   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_dv = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    is_md = sgn || is_dv || (bus.op == OP_MULTU);
    abs_a = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
    abs_b = (sgn && bus.b[W-1]) ? -bus.b : bus.b;
  end

  // work_q: {carry/remainder, low word}; low word is multiplier or quotient
  always_comb begin
    mul_sum = work_q[2*W:W] + (work_q[0] ? {1'b0, dvs_q} : '0);
    div_rs  = work_q[2*W-1:W-1];
    div_ge  = div_rs >= {1'b0, dvs_q};
    div_r   = div_rs[W-1:0] - (div_ge ? dvs_q : '0);
    if (is_div_q)
      step_d = {1'b0, div_r, work_q[W-2:0], div_ge};
    else
      step_d = {1'b0, mul_sum, work_q[W-1:1]};
  end

  always_comb begin
    prod = neg_q ? -work_q[2*W-1:0] : work_q[2*W-1:0];
    quo  = neg_q ? -work_q[W-1:0] : work_q[W-1:0];
    rem  = negr_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];
    hi_d = prod[2*W-1:W];
    lo_d = prod[W-1:0];
    if (is_div_q) begin
      hi_d = bz_q ? a_q : rem;
      lo_d = bz_q ? '1 : quo;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      work_q   <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      bz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.a;
            end else if (is_md) begin
              state_q  <= RUN;
              busy_q   <= 1'b1;
              count_q  <= '0;
              work_q   <= {{(W+1){1'b0}}, abs_a};
              dvs_q    <= abs_b;
              a_q      <= bus.a;
              is_div_q <= is_dv;
              neg_q    <= sgn && (bus.a[W-1] ^ bus.b[W-1]);
              negr_q   <= sgn && bus.a[W-1];
              bz_q     <= (bus.b == '0);
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            work_q  <= step_d;
            count_q <= count_q + 1'b1;
            if (count_q == CW'(W-1))
              state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
endmodule
